// File: rtl/digit_counter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : digit_counter_ctrl
//  Description : Sequencer for a bank of cascaded BCD digit counters. Generates
//                the count tick from a prescaler, drives the per-digit carry
//                chain, issues preset/clear loads and detects target match and
//                all-9s overflow.
//  Revision    : 1.0  initial release
// ============================================================================
module digit_counter_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int TICK_DIV    = 50_000_000,
    parameter bit STOP_AT_MAX = 1'b1
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    start,
    input  logic                    pause_toggle,
    input  logic                    load_req,
    input  logic                    clear_req,
    input  logic [4*NUM_DIGITS-1:0] preset_value,
    input  logic [4*NUM_DIGITS-1:0] target_value,
    input  logic [4*NUM_DIGITS-1:0] digit_count,
    output logic                    digit_enable,
    output logic [NUM_DIGITS-1:0]   digit_loadN,
    output logic [NUM_DIGITS-1:0]   digit_enable_cnt,
    output logic [4*NUM_DIGITS-1:0] digit_init,
    output logic                    running,
    output logic                    done,
    output logic                    overflow
);

    localparam int                   c_PRESC_W   = $clog2(TICK_DIV);
    localparam logic [c_PRESC_W-1:0] c_TICK_LAST = c_PRESC_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [c_PRESC_W-1:0]    presc_q, presc_d;
    logic                    tick_q, tick_d;
    logic [4*NUM_DIGITS-1:0] init_q, init_d;

    logic [NUM_DIGITS-1:0]   w_nine;
    logic [NUM_DIGITS-1:0]   w_tgt_bcd;
    logic [NUM_DIGITS-1:0]   w_carry;
    logic                    w_all9;
    logic                    w_match;
    logic                    w_run_tick;
    logic                    w_stop;
    logic                    w_tick_ok;
    logic                    w_wrap;

    // Per-digit flags: digit at 9, target nibble is valid BCD, carry from below.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign w_nine[gi]    = (digit_count[4*gi +: 4] == 4'd9);
            assign w_tgt_bcd[gi] = (target_value[4*gi +: 4] <= 4'd9);
            if (gi == 0) begin : g_lsd
                assign w_carry[gi] = 1'b1;
            end else begin : g_upper
                assign w_carry[gi] = w_carry[gi-1] & w_nine[gi-1];
            end
        end
    endgenerate

    // A target holding any non-BCD nibble can never be reached by the counters.
    assign w_all9     = &w_nine;
    assign w_match    = (digit_count == target_value) && (&w_tgt_bcd);
    assign w_run_tick = (state_q == S_RUN) && tick_q;
    assign w_stop     = w_run_tick && w_all9 && STOP_AT_MAX;
    assign w_tick_ok  = w_run_tick && !w_match && !(w_all9 && STOP_AT_MAX);
    assign w_wrap     = (presc_q == c_TICK_LAST);

    // State, prescaler and init registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            tick_q  <= 1'b0;
            init_q  <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            init_q  <= init_d;
        end
    end

    // Next-state logic: requests outrank start/pause everywhere except LOAD.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        init_d  = init_q;
        if ((state_q != S_LOAD) && clear_req) begin
            init_d  = '0;
            state_d = S_LOAD;
        end else if ((state_q != S_LOAD) && load_req) begin
            init_d  = preset_value;
            state_d = S_LOAD;
        end else begin
            case (state_q)
                S_LOAD: state_d = S_IDLE;
                S_IDLE: begin
                    if (start) begin
                        state_d = S_RUN;
                        presc_d = '0;
                    end
                end
                S_RUN: begin
                    // Prescaler keeps advancing even on the cycle that pauses,
                    // so a tick raised here is held through PAUSE.
                    presc_d = w_wrap ? '0 : presc_q + 1'b1;
                    tick_d  = w_wrap;
                    if (w_match || w_stop) begin
                        state_d = S_DONE;
                    end else if (pause_toggle) begin
                        state_d = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    tick_d = tick_q;
                    if (pause_toggle) begin
                        state_d = S_RUN;
                    end
                end
                S_DONE:  state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Counter-facing outputs and status flags decoded from the current state.
    always_comb begin
        digit_enable     = (state_q != S_PAUSE);
        digit_loadN      = (state_q == S_LOAD) ? '0 : '1;
        digit_enable_cnt = w_tick_ok ? w_carry : '0;
        digit_init       = init_q;
        running          = (state_q == S_RUN);
        done             = (state_q == S_DONE);
        overflow         = w_run_tick && w_all9;
    end

endmodule
`default_nettype wire

// File: tb/tb_digit_counter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_digit_counter_ctrl
//  Description : Bench for digit_counter_ctrl with a behavioural model of the
//                counter bank and the sequencer, built on decimal integers.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_digit_counter_ctrl;

    localparam int N  = 4;
    localparam int TD = 4;
    localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;

    logic        clk = 1'b0;
    logic        resetN, start, pause_toggle, load_req, clear_req;
    logic [15:0] preset_value, target_value;
    logic [15:0] cnt_s = '0, cnt_w = '0;
    logic        en_s, en_w, run_s, run_w, done_s, done_w, ovf_s, ovf_w;
    logic [3:0]  ldn_s, ldn_w, ec_s, ec_w;
    logic [15:0] init_s, init_w;
    logic        bank_on = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    // Model: mode, prescaler phase, pending tick, counter value, init, target
    int m_mode  = M_IDLE;
    int m_presc = 0;
    int m_tick  = 0;
    int m_val   = 0;
    int m_init  = 0;
    int m_tgt   = 9999;

    always #5 clk = ~clk;

    digit_counter_ctrl #(.NUM_DIGITS(N), .TICK_DIV(TD), .STOP_AT_MAX(1'b1)) dut_s (
        .clk(clk), .resetN(resetN), .start(start), .pause_toggle(pause_toggle),
        .load_req(load_req), .clear_req(clear_req), .preset_value(preset_value),
        .target_value(target_value), .digit_count(cnt_s), .digit_enable(en_s),
        .digit_loadN(ldn_s), .digit_enable_cnt(ec_s), .digit_init(init_s),
        .running(run_s), .done(done_s), .overflow(ovf_s)
    );

    digit_counter_ctrl #(.NUM_DIGITS(N), .TICK_DIV(TD), .STOP_AT_MAX(1'b0)) dut_w (
        .clk(clk), .resetN(resetN), .start(start), .pause_toggle(pause_toggle),
        .load_req(load_req), .clear_req(clear_req), .preset_value(preset_value),
        .target_value(target_value), .digit_count(cnt_w), .digit_enable(en_w),
        .digit_loadN(ldn_w), .digit_enable_cnt(ec_w), .digit_init(init_w),
        .running(run_w), .done(done_w), .overflow(ovf_w)
    );

    // Physical BCD counter bank for the saturating instance
    always @(posedge clk) begin
        if (bank_on && en_s) begin
            for (int i = 0; i < N; i++) begin
                if (!ldn_s[i]) cnt_s[4*i +: 4] <= init_s[4*i +: 4];
                else if (ec_s[i]) cnt_s[4*i +: 4] <= (cnt_s[4*i +: 4] == 4'd9) ? 4'd0 : cnt_s[4*i +: 4] + 4'd1;
            end
        end
    end

    // Physical BCD counter bank for the wrapping instance
    always @(posedge clk) begin
        if (bank_on && en_w) begin
            for (int j = 0; j < N; j++) begin
                if (!ldn_w[j]) cnt_w[4*j +: 4] <= init_w[4*j +: 4];
                else if (ec_w[j]) cnt_w[4*j +: 4] <= (cnt_w[4*j +: 4] == 4'd9) ? 4'd0 : cnt_w[4*j +: 4] + 4'd1;
            end
        end
    end

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int d;
        d = v;
        for (int i = 0; i < N; i++) begin
            r[4*i +: 4] = 4'(d % 10);
            d = d / 10;
        end
        return r;
    endfunction

    function automatic int from_bcd(input logic [15:0] b);
        int v;
        v = 0;
        for (int i = N - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
        return v;
    endfunction

    function automatic bit m_apply();
        return (m_mode == M_RUN) && (m_tick == 1) && (m_val != m_tgt) && (m_val != 9999);
    endfunction

    // Enabled digits = the units digit plus every digit above a run of trailing 9s
    function automatic logic [3:0] m_ecnt();
        int k;
        int v;
        k = 1;
        v = m_val;
        if (!m_apply()) return 4'h0;
        while (k < N && v % 10 == 9) begin
            k++;
            v = v / 10;
        end
        return 4'((1 << k) - 1);
    endfunction

    function automatic logic [43:0] exp_vec();
        return {(m_mode != M_PAUSE), ((m_mode == M_LOAD) ? 4'h0 : 4'hF), m_ecnt(), to_bcd(m_init),
                (m_mode == M_RUN), (m_mode == M_DONE),
                ((m_mode == M_RUN) && (m_tick == 1) && (m_val == 9999)), to_bcd(m_val)};
    endfunction

    function automatic logic [43:0] obs_s();
        return {en_s, ldn_s, ec_s, init_s, run_s, done_s, ovf_s, cnt_s};
    endfunction

    // Advance the model across one clock edge using the inputs now applied
    function automatic void m_next();
        int nm, np, nt, ni, nv;
        nm = m_mode; np = m_presc; nt = 0; ni = m_init; nv = m_val;
        if (m_mode == M_LOAD) nv = m_init;
        else if (m_apply()) nv = (m_val + 1) % 10000;
        if (!resetN) begin
            nm = M_IDLE; np = 0; nt = 0; ni = 0;
        end else if (m_mode != M_LOAD && clear_req) begin
            nm = M_LOAD; ni = 0;
        end else if (m_mode != M_LOAD && load_req) begin
            nm = M_LOAD; ni = from_bcd(preset_value);
        end else begin
            case (m_mode)
                M_LOAD: nm = M_IDLE;
                M_IDLE: if (start) begin nm = M_RUN; np = 0; end
                M_RUN: begin
                    nt = (m_presc == TD - 1) ? 1 : 0;
                    np = (m_presc + 1) % TD;
                    if (m_val == m_tgt || (m_tick == 1 && m_val == 9999)) nm = M_DONE;
                    else if (pause_toggle) nm = M_PAUSE;
                end
                M_PAUSE: begin
                    nt = m_tick;
                    if (pause_toggle) nm = M_RUN;
                end
                default: nm = m_mode;
            endcase
        end
        m_mode = nm; m_presc = np; m_tick = nt; m_init = ni; m_val = nv;
    endfunction

    task automatic step();
        m_next();
        @(posedge clk);
        #1;
    endtask

    task automatic set_target(input int v);
        m_tgt = v;
        target_value = to_bcd(v);
    endtask

    task automatic do_load(input int v);
        preset_value = to_bcd(v);
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        step();
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        step();
        bank_on = 1'b1;
        step();
        resetN = 1'b1;
        n_chk++; if (en_s !== 1'b1) begin n_err++; $display("FAIL reset_enable: got %b expected 1", en_s); end
        n_chk++; if (ldn_s !== 4'hF) begin n_err++; $display("FAIL reset_loadN: got %h expected f", ldn_s); end
        n_chk++; if (ec_s !== 4'h0) begin n_err++; $display("FAIL reset_enable_cnt: got %h expected 0", ec_s); end
        n_chk++; if (init_s !== 16'h0) begin n_err++; $display("FAIL reset_init: got %h expected 0000", init_s); end
        n_chk++; if (run_s !== 1'b0) begin n_err++; $display("FAIL reset_running: got %b expected 0", run_s); end
        n_chk++; if (done_s !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done_s); end
        n_chk++; if (ovf_s !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b expected 0", ovf_s); end
    endtask

    task automatic test_clear_run();
        set_target(9999);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        n_chk++; if (ldn_s !== 4'h0) begin n_err++; $display("FAIL clear_loadN: got %h expected 0", ldn_s); end
        n_chk++; if (obs_s() !== exp_vec()) begin n_err++; $display("FAIL clear_state: got %h expected %h", obs_s(), exp_vec()); end
        step();
        n_chk++; if (ldn_s !== 4'hF || cnt_s !== 16'h0) begin n_err++; $display("FAIL clear_one_cycle: got loadN=%h count=%h expected f/0000", ldn_s, cnt_s); end
        do_start();
        for (int c = 0; c < 41; c++) begin
            step();
            n_chk++; if (obs_s() !== exp_vec()) begin n_err++; $display("FAIL run_model: got %h expected %h", obs_s(), exp_vec()); end
        end
        n_chk++; if (cnt_s !== 16'h0010 || run_s !== 1'b1) begin n_err++; $display("FAIL run_count: got count=%h running=%b expected 0010/1", cnt_s, run_s); end
    endtask

    task automatic test_carry();
        int hits;
        hits = 0;
        do_load(199);
        n_chk++; if (cnt_s !== 16'h0199) begin n_err++; $display("FAIL carry_preset: got %h expected 0199", cnt_s); end
        do_start();
        for (int c = 0; c < 8; c++) begin
            step();
            if (ec_s === 4'b0111) hits++;
            n_chk++; if (obs_s() !== exp_vec()) begin n_err++; $display("FAIL carry_model: got %h expected %h", obs_s(), exp_vec()); end
        end
        n_chk++; if (hits != 1 || cnt_s !== 16'h0200) begin n_err++; $display("FAIL carry_chain: got pulses=%0d count=%h expected 1/0200", hits, cnt_s); end
    endtask

    task automatic test_target();
        int t_reach;
        int t_done;
        t_reach = -1;
        t_done  = -1;
        set_target(8);
        do_load(5);
        do_start();
        for (int c = 1; c <= 40 && t_done < 0; c++) begin
            step();
            if (t_reach < 0 && cnt_s === 16'h0008) t_reach = c;
            if (done_s === 1'b1) t_done = c;
            n_chk++; if (obs_s() !== exp_vec()) begin n_err++; $display("FAIL target_model: got %h expected %h", obs_s(), exp_vec()); end
        end
        n_chk++; if (t_reach < 0 || t_done != t_reach + 1) begin n_err++; $display("FAIL target_done_latency: got reach=%0d done=%0d expected done=reach+1", t_reach, t_done); end
        for (int c = 0; c < 20; c++) begin
            start = (c % 3 == 0);
            step();
            n_chk++; if (cnt_s !== 16'h0008 || done_s !== 1'b1) begin n_err++; $display("FAIL target_hold: got count=%h done=%b expected 0008/1", cnt_s, done_s); end
        end
        start = 1'b0;
    endtask

    task automatic test_pause();
        int k;
        set_target(9999);
        do_load(3);
        do_start();
        step();
        step();
        pause_toggle = 1'b1;
        step();
        pause_toggle = 1'b0;
        for (int c = 0; c < 30; c++) begin
            step();
            n_chk++; if (en_s !== 1'b0 || cnt_s !== 16'h0003) begin n_err++; $display("FAIL pause_frozen: got enable=%b count=%h expected 0/0003", en_s, cnt_s); end
        end
        pause_toggle = 1'b1;
        step();
        pause_toggle = 1'b0;
        k = 0;
        while (cnt_s === 16'h0003 && k < 10) begin
            step();
            k++;
            n_chk++; if (obs_s() !== exp_vec()) begin n_err++; $display("FAIL resume_model: got %h expected %h", obs_s(), exp_vec()); end
        end
        n_chk++; if (k != 2 || cnt_s !== 16'h0004) begin n_err++; $display("FAIL resume_remaining: got %0d cycles count=%h expected 2/0004", k, cnt_s); end
    endtask

    task automatic test_overflow();
        bit found;
        found = 1'b0;
        set_target(1234);
        do_load(9999);
        do_start();
        for (int c = 0; c < 10 && !found; c++) begin
            step();
            if (ovf_s === 1'b1) found = 1'b1;
            n_chk++; if (obs_s() !== exp_vec()) begin n_err++; $display("FAIL ovf_model: got %h expected %h", obs_s(), exp_vec()); end
        end
        n_chk++; if (!found || ec_s !== 4'h0) begin n_err++; $display("FAIL ovf_stop_pulse: got seen=%b enable_cnt=%h expected 1/0", found, ec_s); end
        n_chk++; if (ovf_w !== 1'b1 || ec_w !== 4'hF) begin n_err++; $display("FAIL ovf_wrap_pulse: got overflow=%b enable_cnt=%h expected 1/f", ovf_w, ec_w); end
        step();
        n_chk++; if (ovf_s !== 1'b0 || done_s !== 1'b1 || cnt_s !== 16'h9999) begin n_err++; $display("FAIL ovf_stop_done: got ovf=%b done=%b count=%h expected 0/1/9999", ovf_s, done_s, cnt_s); end
        n_chk++; if (ovf_w !== 1'b0 || run_w !== 1'b1 || done_w !== 1'b0 || cnt_w !== 16'h0) begin n_err++; $display("FAIL ovf_wrap_run: got ovf=%b run=%b done=%b count=%h expected 0/1/0/0000", ovf_w, run_w, done_w, cnt_w); end
        repeat (8) step();
        n_chk++; if (cnt_s !== 16'h9999 || done_s !== 1'b1) begin n_err++; $display("FAIL ovf_stop_hold: got count=%h done=%b expected 9999/1", cnt_s, done_s); end
    endtask

    task automatic test_reset_mid_run();
        int k;
        logic [15:0] v0;
        set_target(9999);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        step();
        do_start();
        repeat (6) step();
        resetN = 1'b0;
        step();
        resetN = 1'b1;
        n_chk++; if ({run_s, done_s, en_s, ldn_s} !== {1'b0, 1'b0, 1'b1, 4'hF}) begin n_err++; $display("FAIL reset_run_idle: got run=%b done=%b en=%b loadN=%h expected 0/0/1/f", run_s, done_s, en_s, ldn_s); end
        n_chk++; if (obs_s() !== exp_vec()) begin n_err++; $display("FAIL reset_run_model: got %h expected %h", obs_s(), exp_vec()); end
        do_start();
        v0 = cnt_s;
        k = 0;
        while (cnt_s === v0 && k < 10) begin
            step();
            k++;
        end
        n_chk++; if (k != 5) begin n_err++; $display("FAIL restart_prescaler: got %0d cycles expected 5", k); end
        preset_value = to_bcd(4321);
        clear_req = 1'b1;
        load_req  = 1'b1;
        step();
        clear_req = 1'b0;
        load_req  = 1'b0;
        n_chk++; if (init_s !== 16'h0 || ldn_s !== 4'h0) begin n_err++; $display("FAIL clear_beats_load: got init=%h loadN=%h expected 0000/0", init_s, ldn_s); end
        step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            clear_req    = ($urandom_range(0, 99) < 2);
            load_req     = ($urandom_range(0, 99) < 3);
            start        = ($urandom_range(0, 99) < 10);
            pause_toggle = ($urandom_range(0, 99) < 4);
            resetN       = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 1) == 1) preset_value = to_bcd(int'($urandom_range(9985, 9999)));
            else preset_value = to_bcd(int'($urandom_range(0, 9999)));
            if ($urandom_range(0, 49) == 0) begin
                if ($urandom_range(0, 5) == 0) begin
                    target_value = 16'h12A4;
                    m_tgt = -1;
                end else begin
                    set_target((m_val + int'($urandom_range(1, 40))) % 10000);
                end
            end
            step();
            n_chk++; if (obs_s() !== exp_vec()) begin n_err++; $display("FAIL random_model: cycle %0d got %h expected %h", c, obs_s(), exp_vec()); end
        end
        clear_req = 1'b0; load_req = 1'b0; start = 1'b0; pause_toggle = 1'b0; resetN = 1'b1;
    endtask

    initial begin
        resetN = 1'b0; start = 1'b0; pause_toggle = 1'b0; load_req = 1'b0; clear_req = 1'b0;
        preset_value = '0;
        target_value = to_bcd(9999);
        test_reset();
        test_clear_run();
        test_carry();
        test_target();
        test_pause();
        test_overflow();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
